// File: rtl/stdp_pkg.sv
// Shared fixed-point types and constants for the STDP spike timer and weight-update blocks.
package stdp_pkg;
  localparam int FP_N = 32;
  localparam int FP_Q = 16;
  localparam int WINDOW_UNITS = 50;

  typedef logic signed [FP_N-1:0] fixed_t;

  localparam fixed_t FP_ZERO    = '0;
  localparam fixed_t FP_MAX     = {1'b0, {(FP_N-1){1'b1}}};
  localparam fixed_t FP_MIN     = {1'b1, {(FP_N-1){1'b0}}};
  localparam fixed_t FP_ONE     = fixed_t'(1 << FP_Q);
  localparam fixed_t WINDOW_DEF = fixed_t'(WINDOW_UNITS << FP_Q);

  typedef enum logic {
    SIDE_EMPTY = 1'b0,
    SIDE_SEEN  = 1'b1
  } side_st_t;
endpackage

// File: rtl/stdp_spike_timer_sat_sub.sv
// Saturating signed subtractor and the non-negative saturating accumulator used for the time base.
module sat_sub #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] y
);
  logic signed [N:0] diff;

  assign diff = {a[N-1], a} - {b[N-1], b};

  always_comb begin
    y = diff[N-1:0];
    if (diff[N] != diff[N-1]) y = diff[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
endmodule

module sat_add #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] a,
  input  logic        [N-1:0] b,
  output logic signed [N-1:0] y,
  output logic                ovf
);
  logic [N:0] sum;

  // a is a non-negative time, b is an increment treated as unsigned
  assign sum = {1'b0, a} + {1'b0, b};
  assign ovf = sum[N] | sum[N-1];
  assign y   = ovf ? {1'b0, {(N-1){1'b1}}} : sum[N-1:0];
endmodule

// File: rtl/stdp_spike_timer.sv
// Spike timestamping and nearest-neighbour pairing; emits t_change with a one-cycle apply pulse.
module stdp_spike_timer
  import stdp_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 16,
  parameter logic signed [N-1:0] WINDOW = N'(WINDOW_UNITS << Q)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                clear,
  input  logic        [N-1:0] dt,
  input  logic                pre_spike,
  input  logic                post_spike,
  output logic signed [N-1:0] t_change,
  output logic                apply,
  output logic                time_sat
);
  localparam logic signed [N-1:0] D_MIN = {1'b1, {(N-1){1'b0}}};

  logic signed [N-1:0] t_now, t_next, last_pre, last_post;
  logic signed [N-1:0] sub_a, sub_b, d_sub, d_p0, d_p1, abs_p1;
  logic                time_ovf, sample, vld_p0, vld_p1, in_win_p1;
  side_st_t            pre_st, post_st;

  assign sample = enable & ~clear;

  sat_add #(.N(N)) u_acc (.a(t_now), .b(dt), .y(t_next), .ovf(time_ovf));
  sat_sub #(.N(N)) u_sub (.a(sub_a), .b(sub_b), .y(d_sub));

  // Stage p0: pair the sampled spike against the most recent opposite spike
  always_comb begin
    sub_a  = t_now;
    sub_b  = last_pre;
    d_p0   = d_sub;
    vld_p0 = 1'b0;
    if (pre_spike && post_spike) begin
      d_p0   = '0;
      vld_p0 = sample;
    end else if (post_spike) begin
      vld_p0 = sample && (pre_st == SIDE_SEEN);
    end else if (pre_spike) begin
      sub_a  = last_post;
      sub_b  = t_now;
      vld_p0 = sample && (post_st == SIDE_SEEN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_now     <= '0;
      last_pre  <= '0;
      last_post <= '0;
      pre_st    <= SIDE_EMPTY;
      post_st   <= SIDE_EMPTY;
      time_sat  <= 1'b0;
    end else if (clear) begin
      t_now    <= '0;
      pre_st   <= SIDE_EMPTY;
      post_st  <= SIDE_EMPTY;
      time_sat <= 1'b0;
    end else if (enable) begin
      t_now    <= t_next;
      time_sat <= time_sat | time_ovf;
      if (pre_spike) begin
        last_pre <= t_now;
        pre_st   <= SIDE_SEEN;
      end
      if (post_spike) begin
        last_post <= t_now;
        post_st   <= SIDE_SEEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    d_p1 <= d_p0;
  end

  // Stage p1: window qualification; FP_MIN never fits because its magnitude is unrepresentable
  always_comb begin
    abs_p1    = d_p1[N-1] ? -d_p1 : d_p1;
    in_win_p1 = (d_p1 != D_MIN) && (abs_p1 <= WINDOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      apply    <= 1'b0;
      t_change <= '0;
    end else begin
      vld_p1 <= vld_p0;
      apply  <= ~clear & vld_p1 & in_win_p1;
      if (!clear && vld_p1 && in_win_p1) t_change <= d_p1;
    end
  end
endmodule

// File: tb/tb_stdp_spike_timer.sv
// Randomised and directed bench for stdp_spike_timer against an event-level reference model.
module tb_stdp_spike_timer;
  logic               clk = 1'b0;
  logic               rst_n, enable, clear, pre_spike, post_spike;
  logic        [31:0] dt;
  logic signed [31:0] t_change;
  logic               apply, time_sat;

  stdp_spike_timer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .dt(dt),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .t_change(t_change), .apply(apply), .time_sat(time_sat)
  );

  always #5 clk = ~clk;

  localparam longint FPMAX = 64'sd2147483647;
  localparam longint FPMIN = -64'sd2147483648;
  localparam longint WIN   = 64'sd50 * 64'sd65536;

  typedef struct {
    int     due;
    longint d;
  } ev_t;

  int     checks = 0;
  int     errors = 0;
  bit     chk_on = 1'b0;
  int     cyc = 0;
  longint mtime, mlpre, mlpost;
  bit     mspre, mspost, msat;
  ev_t    q[$];
  logic        exp_apply, exp_sat;
  logic [31:0] exp_tc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > FPMAX) return FPMAX;
    if (v < FPMIN) return FPMIN;
    return v;
  endfunction

  task automatic model_reset();
    mtime = 0; mlpre = 0; mlpost = 0;
    mspre = 0; mspost = 0; msat = 0;
    q.delete();
    exp_apply = 0; exp_tc = '0; exp_sat = 0;
  endtask

  // One rising edge of the reference: deliver due events, then sample spikes
  task automatic model_edge();
    longint tstamp, d, ad;
    bit have;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (clear) begin
      mtime = 0; mspre = 0; mspost = 0; msat = 0;
      q.delete();
      exp_apply = 0; exp_sat = 0;
      return;
    end
    exp_apply = 0;
    while (q.size() > 0 && q[0].due <= cyc) begin
      ev_t e;
      e = q.pop_front();
      exp_apply = 1;
      exp_tc = e.d[31:0];
    end
    if (enable) begin
      tstamp = mtime;
      have = 0;
      d = 0;
      if (pre_spike && post_spike) have = 1;
      else if (post_spike && mspre) begin d = clamp(tstamp - mlpre); have = 1; end
      else if (pre_spike && mspost) begin d = clamp(mlpost - tstamp); have = 1; end
      if (pre_spike)  begin mlpre = tstamp;  mspre = 1;  end
      if (post_spike) begin mlpost = tstamp; mspost = 1; end
      ad = (d < 0) ? -d : d;
      if (have && d != FPMIN && ad <= WIN) q.push_back('{cyc + 1, d});
      mtime = mtime + longint'(dt);
      if (mtime > FPMAX) begin mtime = FPMAX; msat = 1; end
    end
    exp_sat = msat;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("apply", {31'b0, apply}, {31'b0, exp_apply});
      chk("t_change", t_change, exp_tc);
      chk("time_sat", {31'b0, time_sat}, {31'b0, exp_sat});
    end
  end

  task automatic step(input bit en, input bit clr, input bit pr, input bit po);
    enable = en; clear = clr; pre_spike = pr; post_spike = po;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  task automatic lit(input string nm, input logic [31:0] tc_req, input bit ap_req);
    chk({nm, "_dut_tc"}, t_change, tc_req);
    chk({nm, "_dut_apply"}, {31'b0, apply}, {31'b0, ap_req});
    chk({nm, "_model_tc"}, exp_tc, tc_req);
    chk({nm, "_model_apply"}, {31'b0, exp_apply}, {31'b0, ap_req});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    lit("reset_now", 32'h0, 1'b0);
    chk("reset_now_sat", {31'b0, time_sat}, 32'h0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; pre_spike = 1'b0; post_spike = 1'b0;
    dt = 32'h0001_0000;
    model_reset();
    chk_on = 1'b1;
    #2;
    do_reset();

    // pre at 3.0, post at 10.0
    idle(3); step(1, 0, 1, 0); idle(6); step(1, 0, 0, 1);
    lit("pot_wait", 32'h0, 1'b0);
    idle(1); lit("pot", 32'h0007_0000, 1'b1);
    idle(1); lit("pot_pulse_end", 32'h0007_0000, 1'b0);

    // post at 5.0, pre at 12.0
    step(1, 1, 0, 0); idle(5); step(1, 0, 0, 1); idle(6); step(1, 0, 1, 0);
    idle(1); lit("dep", 32'hFFF9_0000, 1'b1);
    idle(1); lit("dep_pulse_end", 32'hFFF9_0000, 1'b0);

    // earlier pre at 1.0, simultaneous pair at 4.0
    step(1, 1, 0, 0); idle(1); step(1, 0, 1, 0); idle(2); step(1, 0, 1, 1);
    idle(1); lit("same", 32'h0, 1'b1);
    idle(1); lit("same_single", 32'h0, 1'b0);

    // pre at 0, post at 60.0: out of window
    step(1, 1, 0, 0); step(1, 0, 1, 0); idle(59); step(1, 0, 0, 1);
    idle(1); lit("outwin", 32'h0, 1'b0);

    // pre at 60.0, post at 61.0
    step(1, 1, 0, 0); idle(60); step(1, 0, 1, 0); step(1, 0, 0, 1);
    idle(1); lit("inwin", 32'h0001_0000, 1'b1);

    // first-ever spike is a post
    step(1, 1, 0, 0); step(1, 0, 0, 1);
    idle(1); lit("lone_post", 32'h0001_0000, 1'b0);

    // post while disabled is ignored
    step(1, 1, 0, 0); step(1, 0, 1, 0); step(0, 0, 0, 1);
    idle(1); lit("disabled", 32'h0001_0000, 1'b0);
    idle(1); lit("disabled2", 32'h0001_0000, 1'b0);

    // clear between pre and post
    step(1, 1, 0, 0); step(1, 0, 1, 0); step(1, 1, 0, 0); step(1, 0, 0, 1);
    idle(2); lit("clear_mid", 32'h0001_0000, 1'b0);

    // time saturation, pairs still pair with zero difference
    step(1, 1, 0, 0); dt = 32'h4000_0000;
    idle(1); chk("sat_not_yet", {31'b0, time_sat}, 32'h0);
    idle(2); chk("sat_set", {31'b0, time_sat}, 32'h1);
    chk("sat_model_time", mtime[31:0], 32'h7FFF_FFFF);
    step(1, 0, 1, 0); step(1, 0, 0, 1);
    idle(1); lit("sat_pair", 32'h0, 1'b1);
    chk("sat_sticky", {31'b0, time_sat}, 32'h1);
    step(1, 1, 0, 0); chk("sat_cleared", {31'b0, time_sat}, 32'h0);
    dt = 32'h0001_0000;

    // reset one edge after a valid pairing post
    step(1, 0, 1, 0); step(1, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(1); lit("rst_drop", 32'h0, 1'b0);
    end

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0)
        dt = ($urandom_range(0, 19) == 0) ? 32'h2000_0000 : 32'($urandom_range(0, 32'h0006_0000));
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    idle(3);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stdp_spike_timer.md
Name: stdp_spike_timer

Overview:
- Upstream stage of the stdp weight-update block.
- Keeps a fixed-point simulation time, timestamps pre- and post-synaptic spikes, and forms the signed timing difference t_change = t_post - t_pre.
- Issues a one-cycle apply pulse so that stdp latches its dw for exactly one update per pairing event.
- Pairing is nearest-neighbour: each spike pairs with the most recent opposite spike, and spikes are not consumed by pairing.

Parameters:
- N, 32, total width of every fixed-point value (signed two's complement).
- Q, 16, number of fractional bits.
- WINDOW, 32'h0032_0000, maximum |t_change| (raw Q-format value, 50.0) that may produce apply.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  time advances and spikes are sampled only while high.
- clear  input  1  synchronous epoch clear.
- dt  input  N  time increment per enabled cycle, Q format, treated as non-negative.
- pre_spike  input  1  presynaptic spike this cycle.
- post_spike  input  1  postsynaptic spike this cycle.
- t_change  output  N  signed t_post - t_pre, Q format; feeds stdp.t_change.
- apply  output  1  one-cycle pulse marking t_change valid; feeds stdp.apply.
- time_sat  output  1  sticky flag: t_now has saturated.

Behaviour:
- Reset: when rst_n is low, asynchronously clear t_now, last_pre, last_post, pre_seen, post_seen, pipeline valid bits, t_change=0, apply=0 and time_sat=0.
- Time base: on each enabled edge, t_now <= t_now + dt, saturating at FP_MAX (0x7FFF_FFFF). Saturation sets time_sat, which stays set until clear or reset.
- Timestamp: a spike sampled on an enabled edge is stamped with the value t_now held before that edge's increment. When enable is low, spikes are ignored and t_now holds.
- Stage 1 (edge k, spike sampled). Exactly one of these cases applies:
  - post only, pre_seen=1: d1 = T - last_pre (>= 0), v1=1.
  - pre only, post_seen=1: d1 = last_post - T (<= 0), v1=1.
  - pre and post together: d1 = 0, v1=1. Exactly one event is produced, and stdp treats 0 as potentiation.
  - opposite flag 0: v1=0, so an unpaired first spike gives no apply.
  - In all cases, update last_pre/last_post with T and set the matching seen flag on the same edge.
- Subtraction: saturating signed subtraction, clamped to [FP_MIN, FP_MAX].
- Stage 2 (edge k+1):
  - If v1 and |d1| <= WINDOW: t_change <= d1, apply <= 1.
  - Otherwise apply <= 0 and t_change holds its last value.
  - |FP_MIN| is treated as exceeding WINDOW.
- Latency: apply is high during the cycle after edge k+1, i.e. two edges after sampling, for exactly one cycle.
- Throughput: one event per cycle, no backpressure. Back-to-back spikes on consecutive enabled cycles produce back-to-back apply pulses, each carrying its own t_change.
- clear (synchronous, priority over enable and spikes): zero t_now, both seen flags, v1, apply and time_sat. t_change holds. Spikes in the clear cycle are discarded.
- Reset mid-pipeline: any in-flight event is dropped and no apply is issued after reset is released.
- FSM per synapse side: EMPTY -> SEEN on first spike of that type; SEEN -> EMPTY only on clear or reset.

Decomposition:
- Shared package stdp_pkg:
  - typedef fixed_t (signed [N-1:0]).
  - Constants FP_ZERO, FP_MAX, FP_MIN, FP_ONE (1<<Q).
  - Default WINDOW constant, shared with stdp for linear-fit bounds.
- Sub-module sat_sub: combinational saturating signed subtractor, instantiated once in stage 1.
- The time accumulator reuses sat_sub's saturation logic, or an equivalent sat_add in the same file.

Test Plan:
- Reset then dt=0x0001_0000, enable=1:
  - pre at t=3.0, post at t=10.0 -> apply pulse 2 edges after post, t_change=0x0007_0000.
- Post at t=5.0, then pre at t=12.0:
  - -> t_change=0xFFF9_0000 (-7.0), apply=1 for one cycle.
- pre and post in the same cycle at t=4.0, with an earlier pre at t=1.0:
  - -> single apply, t_change=0.
- pre at t=0, post at t=60.0 (outside WINDOW 50.0) -> no apply.
- Post at t=61.0 following a pre at t=60.0 -> apply, t_change=0x0001_0000.
- First-ever spike is post with no pre -> no apply.
- enable low during a spike -> ignored.
- clear between pre and post -> no apply.
- dt=0x4000_0000 for 3 cycles:
  - -> time_sat=1 and t_now=0x7FFF_FFFF.
  - Subsequent pairs still pair, with t_change=0 and apply=1.
- Assert rst_n low one edge after a post spike that forms a valid pair -> apply never asserts, and all outputs are 0 immediately.
